// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin arbiter sharing one data memory port between core and loader
// Each grant takes IDLE -> SERVE -> ACK; memory signals are driven only during SERVE.
module data_mem_arbiter #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [7:0]    c_wdata,
   output logic          c_ack,
   output logic [7:0]    c_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [7:0]    d_wdata,
   output logic          d_ack,
   output logic [7:0]    d_rdata,
   output logic [AW-1:0] memAddress,
   output logic [7:0]    memDataIn,
   output logic          ReadMem,
   output logic          WriteMem,
   input  logic [7:0]    memDataOut
);

   typedef enum logic [1:0] {IDLE, SERVE, ACK} state_t;

   state_t state, state_nx;
   logic   sel, sel_nx;
   logic   last;

   // last resets to the loader so the core wins the first tie
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         sel     <= 1'b0;
         last    <= 1'b1;
         c_rdata <= 8'h00;
         d_rdata <= 8'h00;
      end else begin
         state <= state_nx;
         sel   <= sel_nx;
         if (state == SERVE) begin
            last <= sel;
            if (ReadMem && !sel) c_rdata <= memDataOut;
            if (ReadMem && sel)  d_rdata <= memDataOut;
         end
      end
   end

   always_comb begin
      state_nx   = state;
      sel_nx     = sel;
      memAddress = '0;
      memDataIn  = 8'h00;
      ReadMem    = 1'b0;
      WriteMem   = 1'b0;
      c_ack      = 1'b0;
      d_ack      = 1'b0;
      case (state)
         IDLE: begin
            if (c_req && d_req) begin
               sel_nx   = ~last;
               state_nx = SERVE;
            end else if (c_req) begin
               sel_nx   = 1'b0;
               state_nx = SERVE;
            end else if (d_req) begin
               sel_nx   = 1'b1;
               state_nx = SERVE;
            end
         end
         SERVE: begin
            state_nx = ACK;
            if (sel) begin
               memAddress = d_addr;
               memDataIn  = d_wdata;
               WriteMem   = d_we;
               ReadMem    = ~d_we;
            end else begin
               memAddress = c_addr;
               memDataIn  = c_wdata;
               WriteMem   = c_we;
               ReadMem    = ~c_we;
            end
         end
         ACK: begin
            state_nx = IDLE;
            c_ack    = ~sel;
            d_ack    = sel;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: AW, default 8, data memory address width; this block uses BYTE addresses, so AW SHALL be 8.
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 c_req / c_we  input  1 / 1  core request, and core write (1) or read (0).
REQ-005 c_addr / c_wdata  input  BYTE / BYTE  core address and core write data.
REQ-006 c_ack / c_rdata  output  1 / BYTE  core completion pulse and core read data.
REQ-007 d_req / d_we  input  1 / 1  loader request, and loader write (1) or read (0).
REQ-008 d_addr / d_wdata  input  BYTE / BYTE  loader address and loader write data.
REQ-009 d_ack / d_rdata  output  1 / BYTE  loader completion pulse and loader read data.
REQ-010 memAddress / memDataIn  output  BYTE / BYTE  address and write data to the data memory.
REQ-011 ReadMem / WriteMem  output  1 / 1  memory read enable and write enable.
REQ-012 memDataOut  input  BYTE  combinational memory read data; Z when ReadMem=0.

Function
REQ-013 FSM states: IDLE, SERVE, ACK; a 1-bit register sel records the owner (0=core, 1=loader); a 1-bit register last records the last-served requester.
REQ-014 In IDLE with no request pending: stay in IDLE.
REQ-015 In IDLE with exactly one request pending: go to SERVE with sel set to that requester.
REQ-016 In IDLE with both requests pending: sel SHALL be the requester other than last (round-robin), then go to SERVE.
REQ-017 In SERVE: memAddress, memDataIn, WriteMem=we and ReadMem=~we SHALL come from the selected requester, combinationally from the registered state and sel.
REQ-018 On the posedge ending SERVE: for a read, capture memDataOut into the selected requester's rdata register; set last=sel; go to ACK.
REQ-019 In ACK: assert the selected requester's ack for exactly one cycle, then go to IDLE.
REQ-020 The unselected requester's ack SHALL be 0 in every state.
REQ-021 Outside SERVE: WriteMem=0, ReadMem=0, memAddress=0x00, memDataIn=0x00.
REQ-022 Latency: req seen at edge k -> memory access in cycle k+1 -> ack in cycle k+2; minimum 3 cycles per transaction, including the IDLE cycle.
REQ-023 A requester SHALL hold req, we, addr and wdata stable from assertion until its ack cycle; the arbiter samples them only in IDLE and SERVE.
REQ-024 req still high in the ACK cycle is treated as a new request and is arbitrated in the following IDLE cycle.
REQ-025 Under back-to-back contention, grants SHALL strictly alternate core/loader; neither requester may be served twice in a row while the other is pending.
REQ-026 rdata registers SHALL hold their value until that requester's next completed read; a write SHALL NOT alter rdata.
REQ-027 WriteMem SHALL be asserted for exactly one cycle per write transaction, giving exactly one memory write per transaction.

Reset
REQ-028 reset=1 SHALL immediately (asynchronously) force: state=IDLE, sel=0, last=1, so the core wins the first tie.
REQ-029 reset=1 SHALL also force: c_ack=d_ack=0, c_rdata=d_rdata=0x00.
REQ-030 Memory outputs SHALL drop to the REQ-021 values without waiting for a clock edge.
REQ-031 Reset asserted during SERVE SHALL abort the transaction: no ack, and no write is committed at the next edge.
REQ-032 After reset deasserts, pending requests SHALL be re-arbitrated from IDLE.

Verification
REQ-033 Core write then read: core writes 0xA5 to 0x10, then core reads 0x10 -> each transaction gets one WriteMem/ReadMem cycle; c_ack 2 cycles after req is sampled; c_rdata=0xA5 with c_ack.
REQ-034 Simultaneous first request after reset: both requesters write (core 0x11 to 0x01, loader 0x22 to 0x02) -> core served first, loader next; memory holds 0x11 at 0x01 and 0x22 at 0x02; acks never overlap.
REQ-035 Sustained contention: both hold req high for 8 transactions -> grants alternate C,D,C,D...; each ack is spaced 3 cycles apart.
REQ-036 Reset mid-write: reset asserted in the SERVE cycle of a loader write of 0x77 to 0x30 -> WriteMem falls immediately; M[0x30] unchanged; d_ack never asserted.
REQ-037 Idle bus: no requests for 10 cycles -> ReadMem=WriteMem=0, memAddress=0x00, both acks 0, rdata unchanged.
REQ-038 Loader read during core writes: loader reads 0x40 (preloaded 0x3C) while core issues writes -> d_rdata=0x3C with d_ack; c_rdata unchanged.
